// File: rtl/sync_period_gen.sv
// rtl/sync_period_gen.sv - periodic one-cycle sync strobe generator, armed by a rising edge on arm_in.
// Optional sync counter port enabled by defining SYNC_GEN_COUNT_EN.
module sync_period_gen #(
    parameter int PERIOD_WIDTH = 32
) (
    input  logic                    user_clk,
    input  logic                    user_rst,
    input  logic [PERIOD_WIDTH-1:0] period_in,
    input  logic                    arm_in,
    output logic                    sync_out,
    output logic                    running
`ifdef SYNC_GEN_COUNT_EN
    ,
    output logic [31:0]             sync_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

    state_t                  state;
    state_t                  state_next;
    logic                    arm_d1;
    logic                    arm_d2;
    logic                    arm_edge;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic [PERIOD_WIDTH-1:0] cnt_next;
    logic [PERIOD_WIDTH-1:0] period_shadow;
    logic [PERIOD_WIDTH-1:0] shadow_next;
    logic                    sync_next;
    logic                    period_nz;

    assign period_nz = |period_in;

    // History flops reset high so an arm level held through reset is not an edge.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            arm_d1   <= 1'b1;
            arm_d2   <= 1'b1;
            arm_edge <= 1'b0;
        end else begin
            arm_d1   <= arm_in;
            arm_d2   <= arm_d1;
            arm_edge <= arm_d1 & ~arm_d2;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            period_shadow <= '0;
            sync_out      <= 1'b0;
            running       <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            period_shadow <= shadow_next;
            sync_out      <= sync_next;
            running       <= (state_next == RUN);
        end
    end

    // A restart outranks a coincident wrap, so only one pulse is produced.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        shadow_next = period_shadow;
        sync_next   = 1'b0;
        if (arm_edge) begin
            if (period_nz) begin
                shadow_next = period_in;
                cnt_next    = period_in - ONE;
                sync_next   = 1'b1;
                state_next  = RUN;
            end else begin
                state_next  = IDLE;
            end
        end else if (state == RUN) begin
            if (cnt == '0) begin
                if (period_nz) begin
                    shadow_next = period_in;
                    cnt_next    = period_in - ONE;
                    sync_next   = 1'b1;
                end else begin
                    state_next  = IDLE;
                end
            end else begin
                cnt_next = cnt - ONE;
            end
        end
    end

`ifdef SYNC_GEN_COUNT_EN
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            sync_count <= 32'd0;
        end else if (arm_edge) begin
            sync_count <= {31'd0, sync_next};
        end else if (sync_next) begin
            sync_count <= sync_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_period_gen.sv
// tb/tb_sync_period_gen.sv - self-checking bench for sync_period_gen.
module tb_sync_period_gen;

    logic        user_clk = 1'b0;
    logic        user_rst;
    logic        arm_in;
    logic [31:0] period_in;
    logic        sync_out;
    logic        running;
`ifdef SYNC_GEN_COUNT_EN
    logic [31:0] sync_count;
`endif

    sync_period_gen #(.PERIOD_WIDTH(32)) dut (
        .user_clk  (user_clk),
        .user_rst  (user_rst),
        .period_in (period_in),
        .arm_in    (arm_in),
        .sync_out  (sync_out),
        .running   (running)
`ifdef SYNC_GEN_COUNT_EN
        ,
        .sync_count(sync_count)
`endif
    );

    always #5 user_clk = ~user_clk;

    typedef struct packed {
        logic s;
        logic r;
    } exp_t;

    typedef struct {
        int period;
        int cycles;
        int exp_pulses;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs are queued when the inputs are applied, popped after the edge.
    task automatic step(input logic es, input logic er, input string nm);
        exp_t e;
        exp_q.push_back('{s: es, r: er});
        @(posedge user_clk);
        #1;
        e = exp_q.pop_front();
        check({nm, "_sync"}, 32'(sync_out), 32'(e.s));
        check({nm, "_running"}, 32'(running), 32'(e.r));
        if (sync_out) pulses++;
    endtask

    task automatic do_reset();
        user_rst = 1'b1;
        arm_in   = 1'b0;
        step(1'b0, 1'b0, "reset");
`ifdef SYNC_GEN_COUNT_EN
        check("reset_count", sync_count, 32'd0);
`endif
        user_rst = 1'b0;
    endtask

    // After this, arm_in is high and the next step is edge k.
    task automatic arm_prep(input int p);
        arm_in    = 1'b0;
        period_in = 32'(p);
        step(1'b0, 1'b0, "arm_low");
        step(1'b0, 1'b0, "arm_low");
        arm_in = 1'b1;
    endtask

    initial begin
        vecs[0] = '{period: 5, cycles: 20, exp_pulses: 4};
        vecs[1] = '{period: 1, cycles: 8,  exp_pulses: 6};
        vecs[2] = '{period: 3, cycles: 12, exp_pulses: 4};
        vecs[3] = '{period: 7, cycles: 16, exp_pulses: 2};
        vecs[4] = '{period: 2, cycles: 9,  exp_pulses: 4};

        // Reset hold-off: arm high through reset never starts the generator.
        user_rst  = 1'b1;
        arm_in    = 1'b1;
        period_in = 32'd8;
        step(1'b0, 1'b0, "holdoff_rst");
        user_rst = 1'b0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, "holdoff");

        for (int v = 0; v < 5; v++) begin
            do_reset();
            arm_prep(vecs[v].period);
            pulses = 0;
            for (int i = 0; i < vecs[v].cycles; i++)
                step((i >= 2) && ((i - 2) % vecs[v].period == 0), i >= 2, "basic");
            check("basic_pulses", 32'(pulses), 32'(vecs[v].exp_pulses));
`ifdef SYNC_GEN_COUNT_EN
            check("basic_count", sync_count, 32'(vecs[v].exp_pulses));
`endif
        end

        // Mid-period change to 3, then stop with period 0.
        do_reset();
        arm_prep(5);
        for (int i = 0; i < 20; i++) begin
            step(i == 2 || i == 7 || i == 10 || i == 13, i >= 2 && i < 16, "midchg");
            if (i == 4)  period_in = 32'd3;
            if (i == 14) period_in = 32'd0;
        end

        // Re-arm with period 1: strobe held high.
        arm_in    = 1'b0;
        period_in = 32'd1;
        step(1'b0, 1'b0, "p1_low");
        arm_in = 1'b1;
        for (int i = 0; i < 8; i++) step(i >= 2, i >= 2, "p1");

        // Restart colliding with the wrap at 10, then a mid-period restart at 16.
        do_reset();
        arm_prep(4);
        for (int i = 0; i < 26; i++) begin
            step(i == 2 || i == 6 || i == 10 || i == 14 || i == 16 || i == 20 || i == 24,
                 i >= 2, "restart");
`ifdef SYNC_GEN_COUNT_EN
            if (i == 6)  check("restart_count_pre", sync_count, 32'd2);
            if (i == 10) check("restart_count_collide", sync_count, 32'd1);
            if (i == 16) check("restart_count_mid", sync_count, 32'd1);
            if (i == 20) check("restart_count_after", sync_count, 32'd2);
`endif
            if (i == 6 || i == 12) arm_in = 1'b0;
            if (i == 7 || i == 13) arm_in = 1'b1;
        end

        // Reset one cycle before the pulse due at 14.
        do_reset();
        arm_prep(6);
        for (int i = 0; i < 23; i++) begin
            step(i == 2 || i == 8, i >= 2 && i < 13, "rst_mid");
`ifdef SYNC_GEN_COUNT_EN
            if (i == 13) check("rst_mid_count", sync_count, 32'd0);
`endif
            if (i == 12) user_rst = 1'b1;
            if (i == 13) user_rst = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
